au_sequencer: RTL and testbench

- Multi-cycle controller that owns the 8-bit ripple-carry add/subtract unit (AU) and sequences it to execute ADD, SUB, MUL (8x8 unsigned shift-add) and DIV (8/8 unsigned restoring).
- Sits between the calculator front-end, which issues start/op/operands, and one external AU instance.
- Drives the AU operands and mode combinationally from internal registers, and registers the AU sum/flags each compute cycle.

---
 rtl/au_sequencer.sv | 159 +++++++++++++++
 tb/tb_au_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/au_sequencer.sv
// au_sequencer: multi-cycle controller for an external 8-bit add/subtract unit.
// Runs ADD/SUB in one compute cycle, MUL as 8-step shift-add and DIV as
// 8-step restoring division, all through the single shared AU.
module au_sequencer #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_cout,
  output logic             flag_ovr,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_dbz,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_sub,
  input  logic [WIDTH-1:0] au_s,
  input  logic             au_cout,
  input  logic             au_ovr,
  input  logic             au_zero,
  input  logic             au_neg
);

  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] work_hi, work_lo;   // MUL: P_hi/P_lo, DIV: R/Q
  logic [2:0]       cnt_reg;

  logic             accept;
  logic             div_by_zero;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_r9;
  logic             div_take;
  logic [WIDTH-1:0] div_r_next, div_q_next;

  // Start is only honoured when no operation is in flight.
  assign accept      = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign div_by_zero = (op == OP_DIV) && (opb == '0);

  // One shift-add step: add multiplicand into P_hi when the multiplier LSB is set.
  assign mul_next = work_lo[0] ? {au_cout, au_s, work_lo[WIDTH-1:1]}
                               : {1'b0, work_hi, work_lo[WIDTH-1:1]};

  // One restoring step: trial-subtract divisor from the shifted remainder.
  // The 9th bit covers divisors above 128 where the AU carry alone is not enough.
  assign div_r9     = {work_hi, work_lo[WIDTH-1]};
  assign div_take   = div_r9[WIDTH] | au_cout;
  assign div_r_next = div_take ? au_s : div_r9[WIDTH-1:0];
  assign div_q_next = {work_lo[WIDTH-2:0], div_take};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; the counter's terminal value ends MUL/DIV so it never wraps.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ADDSUB: state_next = S_DONE;
      S_MUL, S_DIV: if (cnt_reg == CNT_LAST) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (accept) begin
      if (div_by_zero)       state_next = S_DONE;
      else if (op == OP_MUL) state_next = S_MUL;
      else if (op == OP_DIV) state_next = S_DIV;
      else                   state_next = S_ADDSUB;
    end
  end

  // Outputs: status from state, AU operands only driven in compute states.
  always_comb begin
    busy   = (state_reg == S_ADDSUB) || (state_reg == S_MUL) || (state_reg == S_DIV);
    done   = (state_reg == S_DONE);
    au_a   = '0;
    au_b   = '0;
    au_sub = 1'b0;
    case (state_reg)
      S_ADDSUB: begin au_a = a_reg; au_b = b_reg; au_sub = op_reg[0]; end
      S_MUL:    begin au_a = work_hi; au_b = a_reg; au_sub = 1'b0; end
      S_DIV:    begin au_a = div_r9[WIDTH-1:0]; au_b = b_reg; au_sub = 1'b1; end
      default:  ;
    endcase
  end

  // Datapath: operand capture, iteration registers, results and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg <= '0; a_reg <= '0; b_reg <= '0;
      work_hi <= '0; work_lo <= '0; cnt_reg <= '0;
      result_lo <= '0; result_hi <= '0;
      flag_cout <= 1'b0; flag_ovr <= 1'b0; flag_zero <= 1'b0;
      flag_neg <= 1'b0; flag_dbz <= 1'b0;
    end else if (accept) begin
      op_reg    <= op;
      a_reg     <= opa;
      b_reg     <= opb;
      cnt_reg   <= '0;
      work_hi   <= '0;
      work_lo   <= (op == OP_MUL) ? opb : opa;
      flag_cout <= 1'b0; flag_ovr <= 1'b0; flag_zero <= 1'b0; flag_neg <= 1'b0;
      // Divide by zero completes immediately with a saturated quotient.
      result_lo <= div_by_zero ? '1 : '0;
      result_hi <= div_by_zero ? opa : '0;
      flag_dbz  <= div_by_zero;
    end else begin
      case (state_reg)
        S_ADDSUB: begin
          result_lo <= au_s;
          result_hi <= '0;
          flag_cout <= au_cout;
          flag_ovr  <= au_ovr;
          flag_zero <= au_zero;
          flag_neg  <= au_neg;
        end
        S_MUL: begin
          {work_hi, work_lo} <= mul_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == CNT_LAST) begin
            {result_hi, result_lo} <= mul_next;
            flag_zero <= (mul_next == '0);
            flag_ovr  <= (mul_next[2*WIDTH-1:WIDTH] != '0);
          end
        end
        S_DIV: begin
          work_hi <= div_r_next;
          work_lo <= div_q_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == CNT_LAST) begin
            result_lo <= div_q_next;
            result_hi <= div_r_next;
            flag_zero <= (div_q_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_sequencer.sv
// Scoreboard bench for au_sequencer with a behavioural model of the external AU.
module tb_au_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] opa = 8'd0, opb = 8'd0;
  logic       busy, done;
  logic [7:0] result_lo, result_hi;
  logic       flag_cout, flag_ovr, flag_zero, flag_neg, flag_dbz;
  logic [7:0] au_a, au_b, au_s;
  logic       au_sub, au_cout, au_ovr, au_zero, au_neg;

  au_sequencer #(.WIDTH(8), .ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flag_cout(flag_cout), .flag_ovr(flag_ovr), .flag_zero(flag_zero),
    .flag_neg(flag_neg), .flag_dbz(flag_dbz),
    .au_a(au_a), .au_b(au_b), .au_sub(au_sub),
    .au_s(au_s), .au_cout(au_cout), .au_ovr(au_ovr), .au_zero(au_zero), .au_neg(au_neg)
  );

  always #5 clk = ~clk;

  // External AU: 8-bit add/subtract with two's-complement flags.
  logic [7:0] bx;
  logic [8:0] sum9;
  always_comb begin
    bx      = au_sub ? ~au_b : au_b;
    sum9    = {1'b0, au_a} + {1'b0, bx} + {8'd0, au_sub};
    au_s    = sum9[7:0];
    au_cout = sum9[8];
    au_ovr  = (au_a[7] == bx[7]) && (sum9[7] != au_a[7]);
    au_zero = (sum9[7:0] == 8'd0);
    au_neg  = sum9[7];
  end

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [4:0] fl;   // {cout, ovr, zero, neg, dbz}
    int         due;  // cycle count at which done must be seen
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [39:0] act, input logic [39:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual lo=%h hi=%h required no done", result_lo, result_hi);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_lo"}, 40'(result_lo), 40'(e.lo));
        chk({e.name, "_hi"}, 40'(result_hi), 40'(e.hi));
        chk({e.name, "_flags"}, 40'({flag_cout, flag_ovr, flag_zero, flag_neg, flag_dbz}), 40'(e.fl));
        chk({e.name, "_latency"}, 40'(cyc), 40'(e.due));
        $display("txn %s lo=%h hi=%h flags=%b cyc=%0d", e.name, result_lo, result_hi,
                 {flag_cout, flag_ovr, flag_zero, flag_neg, flag_dbz}, cyc);
      end
    end
  end

  // Called at a negedge; lat = compute edges after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit expect_it, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [4:0] fl, input int lat, input string nm);
    op = o; opa = a; opb = b; start = 1'b1;
    if (expect_it) begin
      exp_t e;
      e.lo = lo; e.hi = hi; e.fl = fl; e.due = cyc + 1 + lat; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge on which done is high, or reports a timeout.
  task automatic wait_done(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout actual=no done required=done within 40 cycles", nm);
  endtask

  function automatic logic [39:0] all_outs();
    return {busy, done, result_hi, result_lo,
            flag_cout, flag_ovr, flag_zero, flag_neg, flag_dbz, au_a, au_b, au_sub};
  endfunction

  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    chk("reset_state", all_outs(), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 8'd100, 8'd50, 1, 8'd150, 8'd0, 5'b01010, 1, "add_100_50");
    wait_done("add_100_50"); @(negedge clk);
    issue(2'b01, 8'd5, 8'd5, 1, 8'd0, 8'd0, 5'b10100, 1, "sub_5_5");
    wait_done("sub_5_5"); @(negedge clk);
    issue(2'b10, 8'd15, 8'd17, 1, 8'hFF, 8'h00, 5'b00000, 8, "mul_15_17");
    wait_done("mul_15_17"); @(negedge clk);
    issue(2'b10, 8'd255, 8'd255, 1, 8'h01, 8'hFE, 5'b01000, 8, "mul_255_255");
    wait_done("mul_255_255"); @(negedge clk);
    issue(2'b11, 8'd200, 8'd7, 1, 8'd28, 8'd4, 5'b00000, 8, "div_200_7");
    wait_done("div_200_7"); @(negedge clk);
    issue(2'b11, 8'd0, 8'd9, 1, 8'd0, 8'd0, 5'b00100, 8, "div_0_9");
    wait_done("div_0_9"); @(negedge clk);
    issue(2'b10, 8'd16, 8'd16, 1, 8'h00, 8'h01, 5'b01000, 8, "mul_16_16");
    wait_done("mul_16_16"); @(negedge clk);
    issue(2'b11, 8'd37, 8'd0, 1, 8'hFF, 8'd37, 5'b00001, 0, "div_37_0");
    wait_done("div_37_0"); @(negedge clk);
    chk("idle_au_drive", 40'({au_a, au_b, au_sub}), 40'd0);

    // A start pulse during MUL must not disturb the running product.
    issue(2'b10, 8'd12, 8'd13, 1, 8'h9C, 8'h00, 5'b00000, 8, "mul_12_13_ignore");
    repeat (3) @(negedge clk);
    op = 2'b00; opa = 8'd1; opb = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_12_13_ignore"); @(negedge clk);

    // Back-to-back: second start issued in the DONE cycle.
    issue(2'b00, 8'd1, 8'd2, 1, 8'd3, 8'd0, 5'b00000, 1, "add_1_2");
    wait_done("add_1_2");
    issue(2'b01, 8'd3, 8'd5, 1, 8'hFE, 8'd0, 5'b00010, 1, "sub_3_5_b2b");
    wait_done("sub_3_5_b2b"); @(negedge clk);

    // Reset in the middle of DIV aborts with no done.
    issue(2'b11, 8'd200, 8'd7, 0, 8'd0, 8'd0, 5'b00000, 8, "div_abort");
    repeat (3) @(negedge clk);
    chk("div_busy_before_abort", 40'(busy), 40'd1);
    rst_n = 1'b0;
    #1 chk("abort_outputs", all_outs(), 40'd0);
    repeat (3) @(negedge clk);
    chk("abort_held", all_outs(), 40'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("no_done_after_abort", 40'(seen), 40'd0);

    issue(2'b00, 8'd200, 8'd100, 1, 8'd44, 8'd0, 5'b10000, 1, "add_200_100");
    wait_done("add_200_100"); @(negedge clk);

    chk("scoreboard_empty", 40'(sb.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
